// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA stream decoder with lock FSM; VGA_SYNC_DECODER_STATS_EN adds timing stats
module vga_sync_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_clk,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [23:0] vga_rgb,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [8:0]  px_y,
  output logic [23:0] px_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        hlen_err,
  output logic        vlen_err
`ifdef VGA_SYNC_DECODER_STATS_EN
  ,
  output logic [10:0] line_period,
  output logic [9:0]  field_lines,
  output logic [7:0]  err_count
`endif
);

  localparam logic [9:0] H_LEN = 10'(H_ACTIVE);
  localparam logic [8:0] V_LEN = 9'(V_ACTIVE);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;
  state_t state, state_nxt;

  logic        q1_clk, q1_hs, q1_vs, q1_blank_n;
  logic [23:0] q1_rgb;
  logic        q2_clk, q2_hs, q2_vs;
  logic [9:0]  col;
  logic [8:0]  row;
  logic        in_line;
  logic        field_bad;

  logic strobe, hs_ev, vs_ev, act_stb, eol, capture, hlen_det, vlen_det;

  assign strobe   = q1_clk & ~q2_clk;
  assign hs_ev    = ~q1_hs & q2_hs;
  assign vs_ev    = ~q1_vs & q2_vs;
  assign act_stb  = strobe & q1_blank_n;
  // end of line is the first blanked strobe after an active one
  assign eol      = strobe & ~q1_blank_n & in_line;
  assign capture  = act_stb & (state != SEARCH);
  assign hlen_det = eol & (state != SEARCH) & (col != H_LEN);
  assign vlen_det = vs_ev & (state != SEARCH) & (row != V_LEN);
  assign locked   = (state == LOCKED);

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: if (vs_ev) state_nxt = ALIGN;
      ALIGN:  if (vs_ev && !field_bad && !hlen_det && !vlen_det) state_nxt = LOCKED;
      LOCKED: if (hlen_det || vlen_det) state_nxt = ALIGN;
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      q1_clk      <= 1'b0;
      q1_hs       <= 1'b0;
      q1_vs       <= 1'b0;
      q1_blank_n  <= 1'b0;
      q1_rgb      <= '0;
      q2_clk      <= 1'b0;
      q2_hs       <= 1'b0;
      q2_vs       <= 1'b0;
      col         <= '0;
      row         <= '0;
      in_line     <= 1'b0;
      field_bad   <= 1'b0;
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_rgb      <= '0;
      frame_start <= 1'b0;
      hlen_err    <= 1'b0;
      vlen_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      q1_clk     <= vga_clk;
      q1_hs      <= vga_hs;
      q1_vs      <= vga_vs;
      q1_blank_n <= vga_blank_n;
      q1_rgb     <= vga_rgb;
      q2_clk     <= q1_clk;
      q2_hs      <= q1_hs;
      q2_vs      <= q1_vs;

      // counters saturate so an overlong line/field reports instead of aliasing
      if (hs_ev)
        col <= '0;
      else if (act_stb && col != '1)
        col <= col + 10'd1;

      if (vs_ev)
        row <= '0;
      else if (eol && row != '1)
        row <= row + 9'd1;

      if (strobe)
        in_line <= q1_blank_n;

      if (vs_ev)
        field_bad <= 1'b0;
      else if (hlen_det)
        field_bad <= 1'b1;

      px_valid    <= capture;
      frame_start <= capture && (state == LOCKED) && (col == '0) && (row == '0);
      hlen_err    <= hlen_det;
      vlen_err    <= vlen_det;
      if (capture) begin
        px_x   <= col;
        px_y   <= row;
        px_rgb <= q1_rgb;
      end
    end
  end

`ifdef VGA_SYNC_DECODER_STATS_EN
  logic [10:0] hs_gap;
  logic [9:0]  hs_count;
  logic [8:0]  err_sum;

  assign err_sum = {1'b0, err_count} + {8'd0, hlen_err} + {8'd0, vlen_err};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_gap      <= '0;
      hs_count    <= '0;
      line_period <= '0;
      field_lines <= '0;
      err_count   <= '0;
    end else begin
      // hs_gap holds cycles since the last HS minus one
      if (hs_ev) begin
        line_period <= (hs_gap == '1) ? hs_gap : hs_gap + 11'd1;
        hs_gap      <= '0;
      end else if (hs_gap != '1) begin
        hs_gap <= hs_gap + 11'd1;
      end

      if (vs_ev) begin
        field_lines <= hs_count;
        hs_count    <= {9'd0, hs_ev};
      end else if (hs_ev && hs_count != '1) begin
        hs_count <= hs_count + 10'd1;
      end

      err_count <= err_sum[8] ? 8'hff : err_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed bench for vga_sync_decoder on a scaled 8x4 raster
module tb_vga_sync_decoder;

  localparam int H_ACTIVE = 8;
  localparam int V_ACTIVE = 4;
  localparam logic [9:0] LAST_X = 10'(H_ACTIVE - 1);
  localparam logic [8:0] LAST_Y = 9'(V_ACTIVE - 1);

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_clk, vga_hs, vga_vs, vga_blank_n;
  logic [23:0] vga_rgb;
  logic        px_valid, frame_start, locked, hlen_err, vlen_err;
  logic [9:0]  px_x;
  logic [8:0]  px_y;
  logic [23:0] px_rgb;
`ifdef VGA_SYNC_DECODER_STATS_EN
  logic [10:0] line_period;
  logic [9:0]  field_lines;
  logic [7:0]  err_count;
`endif

  vga_sync_decoder #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) dut (
    .clk(clk), .reset(reset), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_rgb(vga_rgb), .px_valid(px_valid), .px_x(px_x),
    .px_y(px_y), .px_rgb(px_rgb), .frame_start(frame_start), .locked(locked),
    .hlen_err(hlen_err), .vlen_err(vlen_err)
`ifdef VGA_SYNC_DECODER_STATS_EN
    , .line_period(line_period), .field_lines(field_lines), .err_count(err_count)
`endif
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  int hi_cyc = 0, vs_cyc = 0;

  int n_valid = 0, n_fs = 0, n_hlen = 0, n_vlen = 0, n_sat = 0, n_lastx = 0, n_lasty = 0;
  int rgb_bad = 0, lat_bad = 0, fs_bad = 0;
  int hlen_cyc = 0, vlen_cyc = 0, lock_rise_cyc = 0, lock_fall_cyc = 0;
  logic prev_locked = 1'b0;

  function automatic logic [23:0] pat(input logic [9:0] x, input logic [8:0] y);
    return {x[7:0], y[7:0], x[7:0] ^ y[7:0]};
  endfunction

  // observer: accumulates per-pixel evidence that the tasks compare as deltas
  initial forever begin
    @(posedge clk);
    #1;
    if (px_valid) begin
      n_valid++;
      if (cyc != hi_cyc + 1) lat_bad++;
      if (px_x == 10'h3ff) n_sat++;
      else if (px_rgb !== pat(px_x, px_y)) rgb_bad++;
      if (px_x == LAST_X) n_lastx++;
      if (px_y == LAST_Y) n_lasty++;
    end
    if (frame_start) begin
      n_fs++;
      if (!(px_valid && px_x == 10'd0 && px_y == 9'd0 && locked)) fs_bad++;
    end
    if (hlen_err) begin n_hlen++; hlen_cyc = cyc; end
    if (vlen_err) begin n_vlen++; vlen_cyc = cyc; end
    if (locked && !prev_locked) lock_rise_cyc = cyc;
    if (!locked && prev_locked) lock_fall_cyc = cyc;
    prev_locked = locked;
  end

  task automatic px(input logic blank_n, input logic hs, input logic vs, input logic [23:0] rgb);
    @(negedge clk);
    vga_clk = 1'b1; vga_hs = hs; vga_vs = vs; vga_blank_n = blank_n; vga_rgb = rgb;
    hi_cyc = cyc + 1;
    @(negedge clk);
    vga_clk = 1'b0;
  endtask

  task automatic drive_line(input int n_act, input int y, input logic vs_low, input int p0, input int p1);
    int len, stop;
    len  = ((n_act > H_ACTIVE) ? n_act : H_ACTIVE) + 4;
    stop = (p1 < 0) ? len : p1;
    for (int p = p0; p < stop; p++) begin
      px((p < n_act) ? 1'b1 : 1'b0, (p == len - 3 || p == len - 2) ? 1'b0 : 1'b1,
         ~vs_low, pat(10'(p), 9'(y)));
      if (vs_low && p == 0) vs_cyc = hi_cyc;
    end
  endtask

  task automatic drive_field(input int n_lines, input int odd_y, input int odd_len);
    for (int y = 0; y < n_lines; y++)
      drive_line((y == odd_y) ? odd_len : H_ACTIVE, y, 1'b0, 0, -1);
    drive_line(0, 0, 1'b1, 0, -1);
    drive_line(0, 0, 1'b0, 0, -1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (px_valid !== 1'b0) begin n_err++; $display("FAIL reset_px_valid: got %0h want 0", px_valid); end
    n_vec++; if (px_x !== 10'd0) begin n_err++; $display("FAIL reset_px_x: got %0h want 0", px_x); end
    n_vec++; if (px_y !== 9'd0) begin n_err++; $display("FAIL reset_px_y: got %0h want 0", px_y); end
    n_vec++; if (px_rgb !== 24'd0) begin n_err++; $display("FAIL reset_px_rgb: got %0h want 0", px_rgb); end
    n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_frame_start: got %0h want 0", frame_start); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %0h want 0", locked); end
    n_vec++; if (hlen_err !== 1'b0) begin n_err++; $display("FAIL reset_hlen_err: got %0h want 0", hlen_err); end
    n_vec++; if (vlen_err !== 1'b0) begin n_err++; $display("FAIL reset_vlen_err: got %0h want 0", vlen_err); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lock();
    int v0, f0, h0, l0, x0, y0;
    // partial field with a short line while searching: nothing may be reported
    v0 = n_valid; h0 = n_hlen; l0 = n_vlen;
    drive_field(2, 0, 5);
    n_vec++; if (n_valid - v0 != 0) begin n_err++; $display("FAIL search_px_valid: got %0d want 0", n_valid - v0); end
    n_vec++; if (n_hlen - h0 != 0 || n_vlen - l0 != 0) begin n_err++; $display("FAIL search_errs: got %0d want 0", n_hlen - h0 + n_vlen - l0); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL align_locked: got %0h want 0", locked); end
    v0 = n_valid; f0 = n_fs;
    drive_field(V_ACTIVE, -1, 0);
    n_vec++; if (n_valid - v0 != H_ACTIVE * V_ACTIVE) begin n_err++; $display("FAIL align_px_count: got %0d want %0d", n_valid - v0, H_ACTIVE * V_ACTIVE); end
    n_vec++; if (n_fs - f0 != 0) begin n_err++; $display("FAIL align_frame_start: got %0d want 0", n_fs - f0); end
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_rise: got %0h want 1", locked); end
    n_vec++; if (lock_rise_cyc != vs_cyc + 1) begin n_err++; $display("FAIL lock_rise_cycle: got %0d want %0d", lock_rise_cyc, vs_cyc + 1); end
    v0 = n_valid; f0 = n_fs; h0 = n_hlen; l0 = n_vlen; x0 = n_lastx; y0 = n_lasty;
    drive_field(V_ACTIVE, -1, 0);
    n_vec++; if (n_valid - v0 != H_ACTIVE * V_ACTIVE) begin n_err++; $display("FAIL locked_px_count: got %0d want %0d", n_valid - v0, H_ACTIVE * V_ACTIVE); end
    n_vec++; if (n_fs - f0 != 1) begin n_err++; $display("FAIL locked_frame_start: got %0d want 1", n_fs - f0); end
    n_vec++; if (n_lastx - x0 != V_ACTIVE) begin n_err++; $display("FAIL last_column_hits: got %0d want %0d", n_lastx - x0, V_ACTIVE); end
    n_vec++; if (n_lasty - y0 != H_ACTIVE) begin n_err++; $display("FAIL last_row_hits: got %0d want %0d", n_lasty - y0, H_ACTIVE); end
    n_vec++; if (n_hlen - h0 != 0 || n_vlen - l0 != 0 || locked !== 1'b1) begin n_err++; $display("FAIL clean_field: errs %0d locked %0h want 0 and 1", n_hlen - h0 + n_vlen - l0, locked); end
`ifdef VGA_SYNC_DECODER_STATS_EN
    n_vec++; if (line_period !== 11'(2 * (H_ACTIVE + 4))) begin n_err++; $display("FAIL line_period: got %0d want %0d", line_period, 2 * (H_ACTIVE + 4)); end
    n_vec++; if (field_lines !== 10'(V_ACTIVE + 2)) begin n_err++; $display("FAIL field_lines: got %0d want %0d", field_lines, V_ACTIVE + 2); end
`endif
  endtask

  task automatic test_short_line();
    int v0, h0, l0, c0;
    v0 = n_valid; h0 = n_hlen; l0 = n_vlen; c0 = cyc;
    drive_field(V_ACTIVE, 1, H_ACTIVE - 1);
    n_vec++; if (n_hlen - h0 != 1) begin n_err++; $display("FAIL short_line_hlen: got %0d want 1", n_hlen - h0); end
    n_vec++; if (n_vlen - l0 != 0) begin n_err++; $display("FAIL short_line_vlen: got %0d want 0", n_vlen - l0); end
    n_vec++; if (lock_fall_cyc != hlen_cyc || lock_fall_cyc < c0) begin n_err++; $display("FAIL short_line_unlock_cycle: got %0d want %0d", lock_fall_cyc, hlen_cyc); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL short_line_stays_align: got %0h want 0", locked); end
    n_vec++; if (n_valid - v0 != H_ACTIVE * V_ACTIVE - 1) begin n_err++; $display("FAIL short_line_px_count: got %0d want %0d", n_valid - v0, H_ACTIVE * V_ACTIVE - 1); end
    drive_field(V_ACTIVE, -1, 0);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL short_line_relock: got %0h want 1", locked); end
  endtask

  task automatic test_short_field();
    int v0, l0;
    v0 = n_valid; l0 = n_vlen;
    drive_field(V_ACTIVE - 1, -1, 0);
    n_vec++; if (n_vlen - l0 != 1) begin n_err++; $display("FAIL short_field_vlen: got %0d want 1", n_vlen - l0); end
    n_vec++; if (vlen_cyc != vs_cyc + 1) begin n_err++; $display("FAIL short_field_vlen_cycle: got %0d want %0d", vlen_cyc, vs_cyc + 1); end
    n_vec++; if (lock_fall_cyc != vlen_cyc || locked !== 1'b0) begin n_err++; $display("FAIL short_field_unlock: got cyc %0d locked %0h want cyc %0d locked 0", lock_fall_cyc, locked, vlen_cyc); end
    n_vec++; if (n_valid - v0 != H_ACTIVE * (V_ACTIVE - 1)) begin n_err++; $display("FAIL short_field_px_count: got %0d want %0d", n_valid - v0, H_ACTIVE * (V_ACTIVE - 1)); end
`ifdef VGA_SYNC_DECODER_STATS_EN
    n_vec++; if (err_count !== 8'd2) begin n_err++; $display("FAIL err_count: got %0d want 2", err_count); end
`endif
    drive_field(V_ACTIVE, -1, 0);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL short_field_relock: got %0h want 1", locked); end
  endtask

  task automatic test_overlong();
    int v0, h0, s0;
    v0 = n_valid; h0 = n_hlen; s0 = n_sat;
    drive_field(V_ACTIVE, 0, 1030);
    n_vec++; if (n_hlen - h0 != 1) begin n_err++; $display("FAIL overlong_hlen: got %0d want 1", n_hlen - h0); end
    n_vec++; if (n_sat - s0 != 7) begin n_err++; $display("FAIL overlong_saturated_px: got %0d want 7", n_sat - s0); end
    n_vec++; if (n_valid - v0 != 1030 + H_ACTIVE * (V_ACTIVE - 1)) begin n_err++; $display("FAIL overlong_px_count: got %0d want %0d", n_valid - v0, 1030 + H_ACTIVE * (V_ACTIVE - 1)); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL overlong_unlock: got %0h want 0", locked); end
    drive_field(V_ACTIVE, -1, 0);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL overlong_relock: got %0h want 1", locked); end
  endtask

  task automatic test_reset_midline();
    int v0, h0, l0;
    drive_line(H_ACTIVE, 0, 1'b0, 0, -1);
    drive_line(H_ACTIVE, 1, 1'b0, 0, -1);
    drive_line(H_ACTIVE, 2, 1'b0, 0, 3);
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (locked !== 1'b1 || px_x !== 10'd2) begin n_err++; $display("FAIL pre_reset_state: got locked %0h x %0d want 1 and 2", locked, px_x); end
    #3 reset = 1'b1;
    #1;
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL midreset_locked: got %0h want 0", locked); end
    n_vec++; if (px_x !== 10'd0 || px_y !== 9'd0) begin n_err++; $display("FAIL midreset_xy: got %0d,%0d want 0,0", px_x, px_y); end
    n_vec++; if (px_rgb !== 24'd0 || px_valid !== 1'b0) begin n_err++; $display("FAIL midreset_pixel: got rgb %0h valid %0h want 0", px_rgb, px_valid); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    v0 = n_valid; h0 = n_hlen; l0 = n_vlen;
    drive_line(H_ACTIVE, 2, 1'b0, 3, -1);
    drive_line(H_ACTIVE, 3, 1'b0, 0, -1);
    drive_line(0, 0, 1'b1, 0, -1);
    drive_line(0, 0, 1'b0, 0, -1);
    n_vec++; if (n_valid - v0 != 0) begin n_err++; $display("FAIL post_reset_px_valid: got %0d want 0", n_valid - v0); end
    n_vec++; if (n_hlen - h0 != 0 || n_vlen - l0 != 0) begin n_err++; $display("FAIL post_reset_errs: got %0d want 0", n_hlen - h0 + n_vlen - l0); end
`ifdef VGA_SYNC_DECODER_STATS_EN
    n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL post_reset_err_count: got %0d want 0", err_count); end
`endif
    v0 = n_valid;
    drive_field(V_ACTIVE, -1, 0);
    n_vec++; if (n_valid - v0 != H_ACTIVE * V_ACTIVE) begin n_err++; $display("FAIL post_reset_field_px: got %0d want %0d", n_valid - v0, H_ACTIVE * V_ACTIVE); end
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL post_reset_relock: got %0h want 1", locked); end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; vga_clk = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1; vga_blank_n = 1'b0; vga_rgb = '0;
    test_reset();
    test_lock();
    test_short_line();
    test_short_field();
    test_overlong();
    test_reset_midline();
    n_vec++; if (rgb_bad != 0) begin n_err++; $display("FAIL pixel_pattern: got %0d bad pixels want 0", rgb_bad); end
    n_vec++; if (lat_bad != 0) begin n_err++; $display("FAIL pixel_latency: got %0d late pixels want 0", lat_bad); end
    n_vec++; if (fs_bad != 0) begin n_err++; $display("FAIL frame_start_position: got %0d misplaced want 0", fs_bad); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
